// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared state encoding, op codes and default width
package muldiv_sequencer_pkg;
   localparam int WIDTH = 32;
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV = 1'b1;
   typedef enum logic [2:0] {IDLE = 3'd0, MULT = 3'd1, DIV = 3'd2, FIX = 3'd3, DONE = 3'd4} state_t;
   function automatic state_t start_state(input logic op, input logic b_zero);
      if (op == OP_MULT) return MULT;
      if (b_zero) return DONE;
      return DIV;
   endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between control FSM and sequencer
interface muldiv_sequencer_if import muldiv_sequencer_pkg::*; #(parameter int WIDTH = muldiv_sequencer_pkg::WIDTH);
   logic Start;
   logic Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic Busy;
   logic Done;
   logic DivZero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   modport master(output Start, Op, A, B, input Busy, Done, DivZero, HI, LO);
   modport slave(input Start, Op, A, B, output Busy, Done, DivZero, HI, LO);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (mult) or restore-subtract (div) iteration
module muldiv_step #(parameter int WIDTH = 32) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic               div_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               q_o
);
   logic [WIDTH:0] sum, upper, diff;
   always_comb begin
      sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, acc_i[0] ? opnd_i : {WIDTH{1'b0}}};
      upper = acc_i[2*WIDTH-1:WIDTH-1];
      diff = upper - {1'b0, opnd_i};
      q_o = div_i & ~diff[WIDTH];
      // quotient bit is left as 0 here; the caller merges q_o into bit 0
      acc_o = div_i ? {q_o ? diff[WIDTH-1:0] : upper[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                    : {sum, acc_i[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle signed MULT/DIV on magnitudes with final sign fix
module muldiv_sequencer import muldiv_sequencer_pkg::*; #(parameter int WIDTH = muldiv_sequencer_pkg::WIDTH) (
   input logic clk,
   input logic reset,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
   logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
   logic op_q, op_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, step_q, neg;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_i(acc_q), .opnd_i(opnd_q), .div_i(op_q == OP_DIV), .acc_o(step_acc), .q_o(step_q)
   );

   always_comb begin
      a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
      b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
      neg = sa_q ^ sb_q;
      prod = neg ? -acc_q : acc_q;
      quo = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      state_d = state_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      opnd_d = opnd_q;
      hi_d = hi_q;
      lo_d = lo_q;
      op_d = op_q;
      sa_d = sa_q;
      sb_d = sb_q;
      dz_d = dz_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               op_d = bus.Op;
               sa_d = bus.A[WIDTH-1];
               sb_d = bus.B[WIDTH-1];
               opnd_d = b_mag;
               acc_d = {{WIDTH{1'b0}}, a_mag};
               cnt_d = '0;
               dz_d = bus.Op == OP_DIV && bus.B == '0;
               state_d = start_state(bus.Op, bus.B == '0);
            end else if (state_q == DONE) state_d = IDLE;
         end
         MULT, DIV: begin
            acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
            cnt_d = cnt_q + 1'b1;
            state_d = cnt_q == CW'(WIDTH-1) ? FIX : state_q;
         end
         FIX: begin
            hi_d = op_q == OP_DIV ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d = op_q == OP_DIV ? quo : prod[WIDTH-1:0];
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         acc_q <= '0;
         opnd_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         op_q <= 1'b0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
         dz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         opnd_q <= opnd_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         op_q <= op_d;
         sa_q <= sa_d;
         sb_q <= sb_d;
         dz_q <= dz_d;
      end
   end

   assign bus.Busy = state_q == MULT || state_q == DIV || state_q == FIX;
   assign bus.Done = state_q == DONE;
   assign bus.DivZero = state_q == DONE && dz_q;
   assign bus.HI = hi_q;
   assign bus.LO = lo_q;
endmodule
